// File: rtl/row_load_buffer_if.sv
// row_load_buffer_if
// Bundles the write stream (row select, word, valid/ready) and the
// assembled-vector handshake toward the systolic array.
// master: upstream row-enable/data source plus the array read side.
// slave : the row_load_buffer itself.
`timescale 1ns/1ps

interface row_load_buffer_if #(
    parameter int ROW    = 9,
    parameter int DATA_W = 8
);
    logic [ROW-1:0]        i_row_sel;
    logic [DATA_W-1:0]     i_data;
    logic                  i_valid;
    logic                  o_ready;
    logic [ROW*DATA_W-1:0] o_vec;
    logic                  o_vec_valid;
    logic                  i_vec_ready;
    logic                  o_err;

    modport master (
        output i_row_sel,
        output i_data,
        output i_valid,
        output i_vec_ready,
        input  o_ready,
        input  o_vec,
        input  o_vec_valid,
        input  o_err
    );

    modport slave (
        input  i_row_sel,
        input  i_data,
        input  i_valid,
        input  i_vec_ready,
        output o_ready,
        output o_vec,
        output o_vec_valid,
        output o_err
    );
endinterface

// File: rtl/row_load_buffer.sv
// row_load_buffer
// Gathers per-row words, steered by a one-hot row select, into a full
// ROW-wide vector for the systolic array's row-injection port.
//
// Build option (macro ROW_BUF_DOUBLE_EN):
//   defined   - two banks used ping-pong: one fills while the other waits
//               for the array, giving full 1 word/cycle throughput.
//   undefined - single bank: writes stall from the cycle after a vector
//               completes through the edge on which the array takes it.
//
// Bank data registers carry no reset; only masks, full flags, bank
// pointers and the error pulse are reset.
`timescale 1ns/1ps

module row_load_buffer #(
    parameter int ROW    = 9,
    parameter int DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    row_load_buffer_if.slave  bus
);

    localparam int IDX_W = (ROW > 1) ? $clog2(ROW) : 1;

`ifdef ROW_BUF_DOUBLE_EN
    localparam int NB = 2;
    // Bank currently being filled / bank currently offered to the array.
    logic wr_bank;
    logic rd_bank;
`else
    localparam int NB = 1;
    // Single bank: both sides always address bank 0.
    localparam logic wr_bank = 1'b0;
    localparam logic rd_bank = 1'b0;
`endif

    // A legal select has exactly one bit set.
    function automatic logic is_onehot(input logic [ROW-1:0] sel);
        return (sel != '0) && ((sel & (sel - ROW'(1))) == '0);
    endfunction

    // Row index of a one-hot select (meaningful only when is_onehot holds).
    function automatic logic [IDX_W-1:0] sel_to_idx(input logic [ROW-1:0] sel);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int r = 0; r < ROW; r++) begin
            if (sel[r]) idx = IDX_W'(r);
        end
        return idx;
    endfunction

    logic [DATA_W-1:0] bank_q [NB][ROW];
    logic [ROW-1:0]    mask_q [NB];
    logic [NB-1:0]     full_q;
    logic              err_p1;

    logic              wr_acc;
    logic              wr_good;
    logic              wr_bad;
    logic              wr_complete;
    logic              pop;
    logic [IDX_W-1:0]  wr_idx;

    assign bus.o_ready     = !full_q[wr_bank];
    assign bus.o_vec_valid = full_q[rd_bank];
    assign bus.o_err       = err_p1;

    assign wr_acc      = bus.i_valid && bus.o_ready;
    assign wr_good     = wr_acc && is_onehot(bus.i_row_sel);
    assign wr_bad      = wr_acc && !is_onehot(bus.i_row_sel);
    assign wr_complete = wr_good && ((mask_q[wr_bank] | bus.i_row_sel) == '1);
    assign pop         = bus.o_vec_valid && bus.i_vec_ready;
    assign wr_idx      = sel_to_idx(bus.i_row_sel);

    // The read bank is never written while full, so o_vec stays stable
    // for as long as it is offered.
    for (genvar r = 0; r < ROW; r++) begin : g_vec
        assign bus.o_vec[r*DATA_W +: DATA_W] = bank_q[rd_bank][r];
    end

    // ---- write stage: data capture into the fill bank (no reset) ----
    always_ff @(posedge i_clk) begin
        if (wr_good) begin
            bank_q[wr_bank][wr_idx] <= bus.i_data;
        end
    end

    // Fill masks, full flags, bank pointers and the dropped-write pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int b = 0; b < NB; b++) begin
                mask_q[b] <= '0;
            end
            full_q <= '0;
            err_p1 <= 1'b0;
`ifdef ROW_BUF_DOUBLE_EN
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
`endif
        end else begin
            err_p1 <= wr_bad;

            if (wr_good) begin
                if (wr_complete) begin
                    // Last missing row: hand the bank over and start the
                    // next fill with an empty mask.
                    mask_q[wr_bank] <= '0;
                    full_q[wr_bank] <= 1'b1;
`ifdef ROW_BUF_DOUBLE_EN
                    wr_bank <= ~wr_bank;
`endif
                end else begin
                    // Re-writing an already filled row only replaces data.
                    mask_q[wr_bank] <= mask_q[wr_bank] | bus.i_row_sel;
                end
            end

            // Completion targets a non-full bank and pop a full one, so
            // the two never touch the same flag on one edge.
            if (pop) begin
                full_q[rd_bank] <= 1'b0;
`ifdef ROW_BUF_DOUBLE_EN
                rd_bank <= ~rd_bank;
`endif
            end
        end
    end

endmodule

// File: tb/tb_row_load_buffer.sv
// tb_row_load_buffer
// Directed stimulus with a queue of hand-computed expected vectors; a
// negedge monitor compares every vector the array accepts.
// Expectations follow the ROW_BUF_DOUBLE_EN build option.
`timescale 1ns/1ps

module tb_row_load_buffer;

    localparam int ROW    = 3;
    localparam int DATA_W = 8;
    localparam int VW     = ROW * DATA_W;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    row_load_buffer_if #(.ROW(ROW), .DATA_W(DATA_W)) bus ();

    row_load_buffer #(.ROW(ROW), .DATA_W(DATA_W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [VW-1:0] exp_q [$];

    int low_cnt  = 0;
    bit count_en = 1'b0;

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_vec(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%06h expected 0x%06h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every accepted vector must match the oldest expected one.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.o_vec_valid === 1'b1 && bus.i_vec_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_vec: got 0x%06h expected no vector", bus.o_vec);
            end else begin
                check_vec("vec_out", bus.o_vec, exp_q.pop_front());
            end
        end
    end

    // Counts write-side stall cycles during the streaming test.
    always @(negedge clk) begin
        if (count_en && bus.o_ready === 1'b0) low_cnt++;
    end

    // Waits (bounded) for o_ready, then issues one write cycle.
    // Entered and left just after a rising edge.
    task automatic do_write(input logic [ROW-1:0] sel, input logic [DATA_W-1:0] d);
        int n = 0;
        while (bus.o_ready !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 40) begin
            n_checks++;
            n_fail++;
            $display("FAIL write_timeout: o_ready got 0 expected 1");
        end
        bus.i_valid   = 1'b1;
        bus.i_row_sel = sel;
        bus.i_data    = d;
        @(posedge clk); #1;
        bus.i_valid   = 1'b0;
        bus.i_row_sel = '0;
        bus.i_data    = '0;
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        check_int({tag, "_pending"}, exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation got stuck, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n           = 1'b0;
        bus.i_valid     = 1'b0;
        bus.i_row_sel   = '0;
        bus.i_data      = '0;
        bus.i_vec_ready = 1'b0;
        #1;
        check_bit("rst_ready", bus.o_ready, 1'b1);
        check_bit("rst_vvalid", bus.o_vec_valid, 1'b0);
        check_bit("rst_err", bus.o_err, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Basic fill and immediate pop.
        bus.i_vec_ready = 1'b1;
        exp_q.push_back(24'h332211);
        do_write(3'b001, 8'h11);
        do_write(3'b010, 8'h22);
        do_write(3'b100, 8'h33);
        check_bit("t1_vvalid", bus.o_vec_valid, 1'b1);
        check_vec("t1_vec", bus.o_vec, 24'h332211);
        check_bit("t1_err", bus.o_err, 1'b0);
`ifdef ROW_BUF_DOUBLE_EN
        check_bit("t1_ready", bus.o_ready, 1'b1);
`else
        check_bit("t1_ready", bus.o_ready, 1'b0);
`endif
        idle(1);
        check_bit("t1_popped", bus.o_vec_valid, 1'b0);
        check_bit("t1_ready_after", bus.o_ready, 1'b1);
        drain("t1");

        // Backpressure from the array.
        bus.i_vec_ready = 1'b0;
        exp_q.push_back(24'h332211);
        exp_q.push_back(24'h665544);
`ifdef ROW_BUF_DOUBLE_EN
        do_write(3'b001, 8'h11);
        do_write(3'b010, 8'h22);
        do_write(3'b100, 8'h33);
        do_write(3'b001, 8'h44);
        do_write(3'b010, 8'h55);
        do_write(3'b100, 8'h66);
        check_bit("t2_ready_full", bus.o_ready, 1'b0);
        check_bit("t2_vvalid", bus.o_vec_valid, 1'b1);
        idle(2);
        check_vec("t2_hold", bus.o_vec, 24'h332211);
        check_bit("t2_ready_hold", bus.o_ready, 1'b0);
        bus.i_vec_ready = 1'b1;
        idle(1);
        check_bit("t2_ready_pop1", bus.o_ready, 1'b1);
        check_bit("t2_vvalid_pop1", bus.o_vec_valid, 1'b1);
        check_vec("t2_vec2", bus.o_vec, 24'h665544);
        idle(1);
        check_bit("t2_vvalid_pop2", bus.o_vec_valid, 1'b0);
`else
        do_write(3'b001, 8'h11);
        do_write(3'b010, 8'h22);
        do_write(3'b100, 8'h33);
        check_bit("t2_ready_full", bus.o_ready, 1'b0);
        check_bit("t2_vvalid", bus.o_vec_valid, 1'b1);
        idle(2);
        check_vec("t2_hold", bus.o_vec, 24'h332211);
        check_bit("t2_ready_hold", bus.o_ready, 1'b0);
        bus.i_vec_ready = 1'b1;
        idle(1);
        check_bit("t2_ready_pop1", bus.o_ready, 1'b1);
        check_bit("t2_vvalid_pop1", bus.o_vec_valid, 1'b0);
        bus.i_vec_ready = 1'b0;
        do_write(3'b001, 8'h44);
        do_write(3'b010, 8'h55);
        do_write(3'b100, 8'h66);
        check_bit("t2_vvalid2", bus.o_vec_valid, 1'b1);
        check_vec("t2_vec2", bus.o_vec, 24'h665544);
        bus.i_vec_ready = 1'b1;
        idle(1);
        check_bit("t2_vvalid_pop2", bus.o_vec_valid, 1'b0);
`endif
        drain("t2");

        // Malformed selects are dropped with a one-cycle error pulse.
        bus.i_vec_ready = 1'b1;
        do_write(3'b011, 8'h77);
        check_bit("t3_err_multi", bus.o_err, 1'b1);
        check_bit("t3_vvalid_multi", bus.o_vec_valid, 1'b0);
        idle(1);
        check_bit("t3_err_multi_end", bus.o_err, 1'b0);
        do_write(3'b000, 8'h77);
        check_bit("t3_err_zero", bus.o_err, 1'b1);
        idle(1);
        check_bit("t3_err_zero_end", bus.o_err, 1'b0);
        exp_q.push_back(24'h030201);
        do_write(3'b001, 8'h01);
        check_bit("t3_vvalid_part", bus.o_vec_valid, 1'b0);
        do_write(3'b010, 8'h02);
        check_bit("t3_vvalid_part2", bus.o_vec_valid, 1'b0);
        do_write(3'b100, 8'h03);
        check_bit("t3_vvalid", bus.o_vec_valid, 1'b1);
        check_bit("t3_err_good", bus.o_err, 1'b0);
        drain("t3");

        // Overwrite of an already written row.
        exp_q.push_back(24'h3322BB);
        do_write(3'b001, 8'hAA);
        do_write(3'b001, 8'hBB);
        do_write(3'b010, 8'h22);
        check_bit("t4_vvalid_part", bus.o_vec_valid, 1'b0);
        do_write(3'b100, 8'h33);
        check_bit("t4_vvalid", bus.o_vec_valid, 1'b1);
        drain("t4");

        // Asynchronous reset mid-fill discards the partial vector.
        bus.i_vec_ready = 1'b0;
        do_write(3'b001, 8'h11);
        do_write(3'b010, 8'h22);
        #2 rst_n = 1'b0;
        #1;
        check_bit("t5_rst_vvalid", bus.o_vec_valid, 1'b0);
        check_bit("t5_rst_ready", bus.o_ready, 1'b1);
        @(posedge clk); #1 rst_n = 1'b1;
        bus.i_vec_ready = 1'b1;
        exp_q.push_back(24'h998877);
        do_write(3'b100, 8'h99);
        check_bit("t5_fresh_part", bus.o_vec_valid, 1'b0);
        do_write(3'b010, 8'h88);
        do_write(3'b001, 8'h77);
        check_bit("t5_fresh_vvalid", bus.o_vec_valid, 1'b1);
        drain("t5");
        idle(2);

        // Reset while a complete vector is waiting for the array.
        bus.i_vec_ready = 1'b0;
        do_write(3'b001, 8'h11);
        do_write(3'b010, 8'h22);
        do_write(3'b100, 8'h33);
        check_bit("t5b_vvalid", bus.o_vec_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_bit("t5b_rst_vvalid", bus.o_vec_valid, 1'b0);
        check_bit("t5b_rst_ready", bus.o_ready, 1'b1);
        @(posedge clk); #1 rst_n = 1'b1;
        bus.i_vec_ready = 1'b1;
        idle(3);
        check_bit("t5b_no_vec", bus.o_vec_valid, 1'b0);

        // Streaming six words with the array always ready.
        exp_q.push_back(24'h332211);
        exp_q.push_back(24'h665544);
        low_cnt  = 0;
        count_en = 1'b1;
        do_write(3'b001, 8'h11);
        do_write(3'b010, 8'h22);
        do_write(3'b100, 8'h33);
        do_write(3'b001, 8'h44);
        do_write(3'b010, 8'h55);
        do_write(3'b100, 8'h66);
        count_en = 1'b0;
`ifdef ROW_BUF_DOUBLE_EN
        check_int("t6_stall_cycles", low_cnt, 0);
`else
        check_int("t6_stall_cycles", low_cnt, 1);
`endif
        drain("t6");
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/row_load_buffer.md
# row_load_buffer

Collects a stream of per-row data words, steered by the one-hot row-enable vector from the row shift register, into a full ROW-wide vector for the systolic array's row inputs. Sits directly downstream of the rotating one-hot row-enable generator and upstream of the array's row-injection port. Ping-pong banking lets one vector be filled while the previous one waits for the array to take it.

## Interface
Parameters:
- ROW, 9, number of array rows; width of the one-hot select and number of words per vector
- DATA_W, 8, width of one row word

Ports:
- i_clk  input  1  clock, rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_row_sel  input  ROW  one-hot row select, driven by the row-enable generator
- i_data  input  DATA_W  word for the selected row
- i_valid  input  1  i_data/i_row_sel valid this cycle
- o_ready  output  1  buffer can accept a write this cycle
- o_vec  output  ROW*DATA_W  assembled vector; row r at bits [r*DATA_W +: DATA_W]
- o_vec_valid  output  1  o_vec holds a complete vector
- i_vec_ready  input  1  array consumes o_vec this cycle
- o_err  output  1  one-cycle pulse, malformed select dropped

## Operation
- Storage: NB banks of ROW x DATA_W registers, each with a fill mask [ROW-1:0] and a full flag. NB=2 with ROW_BUF_DOUBLE_EN, NB=1 without. Pointers wr_bank and rd_bank are 1 bit each, fixed at 0 when NB=1.
- o_ready = !full[wr_bank]. A write is accepted when i_valid && o_ready.
- An accepted write with one-hot i_row_sel stores i_data into row index(sel) of bank wr_bank and ORs i_row_sel into the mask.
- Re-writing a row whose mask bit is already set overwrites the data; the mask is unchanged. This is legal.
- A write with i_row_sel zero or multi-hot while i_valid && o_ready is dropped: no data or mask change. o_err pulses high for the next cycle.
- Completion: if (mask | i_row_sel) == all ones on an accepted write, set full[wr_bank] and clear that mask on the same edge. With NB=2, wr_bank also toggles on that edge.
- Read side: o_vec_valid = full[rd_bank]; o_vec = bank[rd_bank] data, held stable while o_vec_valid && !i_vec_ready.
- Pop: when o_vec_valid && i_vec_ready, clear full[rd_bank]. With NB=2, rd_bank also toggles.
- Both banks full: o_ready=0. Upstream must hold the row-enable generator disabled.
- Bank data registers are not reset; only masks, flags, pointers and o_err are reset.

## Timing
- Reset (async assert, sync-safe release) sets: masks=0, full=0, wr_bank=rd_bank=0, o_ready=1, o_vec_valid=0, o_err=0. o_vec is don't-care until the first o_vec_valid.
- Reset mid-fill or mid-handshake discards all partial and complete vectors.
- Latency: the write completing a vector at edge N gives o_vec_valid=1 after edge N, i.e. 1 cycle.
- Full throughput with NB=2: back-to-back vectors at 1 word/cycle with no stall, provided i_vec_ready is asserted within ROW cycles of o_vec_valid.
- Simultaneous completion and pop (NB=2, different banks): both take effect on the same edge.
- NB=1: o_ready=0 while full. The earliest next write is the cycle after the pop edge, so there is no same-cycle bypass.
- o_err: registered, exactly 1 cycle per dropped write.

## Configuration
- ROW_BUF_DOUBLE_EN defined: two banks, ping-pong operation as above.
- ROW_BUF_DOUBLE_EN undefined: single bank. o_ready falls for the cycle after completion through the pop edge, with 1 bubble cycle per vector minimum. Pointers are removed.

## Test plan
- ROW=3, DATA_W=8, NB=2. Writes sel=001/010/100 with data 0x11/0x22/0x33 on consecutive cycles, i_vec_ready=1 -> o_vec_valid=1 the cycle after the third write, o_vec=0x332211, popped the same cycle.
- i_vec_ready=0. Fill two vectors (0x332211, then 0x665544) -> o_ready=0 after the 6th write. Raise i_vec_ready -> 0x332211 then 0x665544 delivered in order, and o_ready returns to 1 after the first pop.
- sel=011 with i_valid=1 -> o_err=1 for 1 cycle, mask unchanged, no o_vec_valid. sel=000 -> same.
- Writes sel=001 with 0xAA, then 001 with 0xBB, then 010, then 100 -> vector completes after the 4th write, and the row 0 field reads 0xBB.
- Assert i_rst_n=0 asynchronously after 2 of 3 writes -> o_vec_valid=0 and o_ready=1 immediately. Three fresh writes then produce exactly one vector.
- ROW_BUF_DOUBLE_EN undefined: stream 6 words with i_vec_ready=1 -> o_ready is low 1 cycle between vectors, and two vectors are delivered correctly.
